// File: rtl/serial_alu_seq.sv
// Bit-serial word sequencer around an external one-bit ALU slice.
// Drives the slice LSB first and collects result, carry, overflow.
module serial_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             sl_a,
  output logic             sl_b,
  output logic             sl_cin,
  output logic             sl_s1,
  output logic             sl_s0,
  input  logic             sl_out,
  input  logic             sl_cout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_cin;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic             w_add;
  logic [WIDTH-1:0] w_res_next;

  assign w_add      = (r_op == 2'b11);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_accept   = (r_state == IDLE) && start;
  assign w_res_next = {sl_out, r_result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    sl_a   = 1'b0;
    sl_b   = 1'b0;
    sl_cin = 1'b0;
    sl_s1  = 1'b0;
    sl_s0  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        sl_a   = r_a[0];
        sl_b   = r_b[0];
        sl_cin = w_add & r_cin;
        sl_s1  = r_op[1];
        sl_s0  = r_op[0];
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cin    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      // subtract as A + ~B + 1
      r_b   <= (sub && op == 2'b11) ? ~b : b;
      r_op  <= op;
      r_cin <= sub && (op == 2'b11);
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_cin    <= sl_cout;
      r_cnt    <= r_cnt + 1'b1;
      r_result <= w_res_next;
      if (w_last) begin
        r_carry <= w_add & sl_cout;
        r_ovf   <= w_add & (sl_cin ^ sl_cout);
        r_zero  <= (w_res_next == '0);
      end
    end
  end

  assign result = r_result;
  assign carry  = r_carry;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a behavioural slice model.
// Each task drives one scenario and checks its own results inline.
module tb_serial_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       sub;
  logic       busy, done, carry, ovf, zero;
  logic [7:0] result;
  logic       sl_a, sl_b, sl_cin, sl_s1, sl_s0;
  logic       sl_out, sl_cout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .op(op), .sub(sub),
    .busy(busy), .done(done), .result(result),
    .carry(carry), .ovf(ovf), .zero(zero),
    .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin),
    .sl_s1(sl_s1), .sl_s0(sl_s0),
    .sl_out(sl_out), .sl_cout(sl_cout)
  );

  // slice: cout is the full-adder carry regardless of select
  always_comb begin
    case ({sl_s1, sl_s0})
      2'b00:   sl_out = sl_a & sl_b;
      2'b01:   sl_out = sl_a | sl_b;
      2'b10:   sl_out = sl_a ^ sl_b;
      default: sl_out = sl_a ^ sl_b ^ sl_cin;
    endcase
    sl_cout = (sl_a & sl_b) | (sl_cin & (sl_a ^ sl_b));
  end

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [1:0] iop, input logic isub,
                        output int lat, output logic [7:0] cinv);
    @(negedge clk);
    a = ia; b = ib; op = iop; sub = isub; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    cinv = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (n < 8) cinv[3'(n)] = sl_cin;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'hFF; b = 8'hFF; op = 2'b11; sub = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, result, carry, ovf, zero} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_out: busy=%b done=%b res=%h c=%b v=%b z=%b want 0",
               busy, done, result, carry, ovf, zero);
    end
    n_vec++;
    if ({sl_a, sl_b, sl_cin, sl_s1, sl_s0} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_sl: got %b want 00000",
               {sl_a, sl_b, sl_cin, sl_s1, sl_s0});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    logic [7:0] cinv;
    run_op(8'h3C, 8'h55, 2'b11, 1'b0, lat, cinv);
    n_vec++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL add_latency: got %0d want 8", lat);
    end
    n_vec++;
    if ({result, carry, ovf, zero, busy} !== {8'h91, 4'b0101}) begin
      n_err++;
      $display("FAIL add_res: res=%h c=%b v=%b z=%b busy=%b want 91 0 1 0 1",
               result, carry, ovf, zero, busy);
    end
    n_vec++;
    if (cinv !== 8'hF8) begin
      n_err++;
      $display("FAIL add_cin_seq: got %b want 11111000", cinv);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL add_done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
    a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({result, ovf, sl_a, sl_b, sl_cin, sl_s1, sl_s0} !== {8'h91, 6'b100000}) begin
      n_err++;
      $display("FAIL idle_hold: res=%h v=%b sl=%b want 91 1 00000",
               result, ovf, {sl_a, sl_b, sl_cin, sl_s1, sl_s0});
    end
  endtask

  task automatic test_sub();
    int lat;
    logic [7:0] cinv;
    run_op(8'h10, 8'h01, 2'b11, 1'b1, lat, cinv);
    n_vec++;
    if ({result, carry, ovf, zero} !== {8'h0F, 3'b100} || lat !== 8) begin
      n_err++;
      $display("FAIL sub_10_01: res=%h c=%b v=%b z=%b lat=%0d want 0f 1 0 0 8",
               result, carry, ovf, zero, lat);
    end
    n_vec++;
    if (cinv[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sub_cin0: got %b want 1", cinv[0]);
    end
    run_op(8'h00, 8'h01, 2'b11, 1'b1, lat, cinv);
    n_vec++;
    if ({result, carry, ovf, zero} !== {8'hFF, 3'b000}) begin
      n_err++;
      $display("FAIL sub_00_01: res=%h c=%b v=%b z=%b want ff 0 0 0",
               result, carry, ovf, zero);
    end
  endtask

  task automatic test_logic();
    int lat;
    logic [7:0] cinv;
    run_op(8'hF0, 8'h3C, 2'b00, 1'b1, lat, cinv);
    n_vec++;
    if ({result, carry, ovf, zero} !== {8'h30, 3'b000} || cinv !== 8'h00) begin
      n_err++;
      $display("FAIL and: res=%h c=%b v=%b z=%b cin=%b want 30 0 0 0 0",
               result, carry, ovf, zero, cinv);
    end
    run_op(8'hF0, 8'h3C, 2'b01, 1'b0, lat, cinv);
    n_vec++;
    if ({result, carry, ovf, zero} !== {8'hFC, 3'b000} || cinv !== 8'h00) begin
      n_err++;
      $display("FAIL or: res=%h c=%b v=%b z=%b cin=%b want fc 0 0 0 0",
               result, carry, ovf, zero, cinv);
    end
    run_op(8'hAA, 8'hAA, 2'b10, 1'b0, lat, cinv);
    n_vec++;
    if ({result, carry, ovf, zero} !== {8'h00, 3'b001} || cinv !== 8'h00) begin
      n_err++;
      $display("FAIL xor: res=%h c=%b v=%b z=%b cin=%b want 00 0 0 1 0",
               result, carry, ovf, zero, cinv);
    end
  endtask

  task automatic test_start_busy();
    int lat = -1;
    int extra = 0;
    @(negedge clk);
    a = 8'h3C; b = 8'h55; op = 2'b11; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      start = (n == 1 || n == 7);
      if (start) begin
        a = 8'hFF; b = 8'hFF; op = 2'b00; sub = 1'b1;
      end
    end
    start = 1'b0;
    n_vec++;
    if (lat !== 8 || result !== 8'h91 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL busy_ignore: lat=%0d res=%h v=%b want 8 91 1",
               lat, result, ovf);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL busy_single_done: extra dones %0d want 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [7:0] cinv;
    @(negedge clk);
    a = 8'h3C; b = 8'h55; op = 2'b11; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({busy, sl_s1, sl_s0} !== 3'b111) begin
      n_err++;
      $display("FAIL run_drive: busy=%b s1s0=%b%b want 1 11", busy, sl_s1, sl_s0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, result, carry, ovf, zero,
         sl_a, sl_b, sl_cin, sl_s1, sl_s0} !== 18'h0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b done=%b res=%h cvz=%b%b%b sl=%b want all 0",
               busy, done, result, carry, ovf, zero,
               {sl_a, sl_b, sl_cin, sl_s1, sl_s0});
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h10, 8'h01, 2'b11, 1'b1, lat, cinv);
    n_vec++;
    if ({result, carry, ovf} !== {8'h0F, 2'b10} || lat !== 8) begin
      n_err++;
      $display("FAIL after_reset: res=%h c=%b v=%b lat=%0d want 0f 1 0 8",
               result, carry, ovf, lat);
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int bad_res = 0;
    @(negedge clk);
    a = 8'h01; b = 8'h02; op = 2'b11; sub = 1'b0; start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        t.push_back(n);
        if (result !== 8'h03) bad_res++;
      end
    end
    start = 1'b0;
    n_vec++;
    if (t.size() < 3 || bad_res !== 0) begin
      n_err++;
      $display("FAIL b2b_count: dones=%0d bad=%0d want >=3 0", t.size(), bad_res);
    end
    for (int i = 1; i < t.size(); i++) begin
      n_vec++;
      if (t[i] - t[i-1] !== 10) begin
        n_err++;
        $display("FAIL b2b_period: got %0d want 10", t[i] - t[i-1]);
      end
    end
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_start_busy();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
